// File: rtl/cw305_usb_master.sv
// Host-side initiator for the CW305 parallel USB register bus.
// Turns single-byte read/write commands into timed cen/rdn/wrn bus cycles and returns the read byte.
module cw305_usb_master #(
  parameter int pADDR_WIDTH   = 21,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_write_i,
  input  logic [pADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [7:0]             cmd_wdata_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [7:0]             rsp_rdata_o,
  output logic                   busy_o,
  output logic [pADDR_WIDTH-1:0] usb_addr_o,
  output logic [7:0]             usb_data_o,
  output logic                   usb_data_oe_o,
  input  logic [7:0]             usb_data_i,
  output logic                   usb_rdn_o,
  output logic                   usb_wrn_o,
  output logic                   usb_cen_o
);

  localparam int MAX_SS = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_C  = (MAX_SS > HOLD_CYCLES) ? MAX_SS : HOLD_CYCLES;
  localparam int CNT_W  = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   write_q;
  logic                   cmd_ready_q;
  logic                   rsp_valid_q;
  logic [7:0]             rsp_rdata_q;
  logic                   busy_q;
  logic [pADDR_WIDTH-1:0] addr_q;
  logic [7:0]             data_q;
  logic                   oe_q;
  logic                   rdn_q;
  logic                   wrn_q;
  logic                   cen_q;

  wire last_q = (cnt_q == CNT_W'(1));

  // All outputs are registered; each is updated on the edge that enters the phase it belongs to.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      oe_q        <= 1'b0;
      rdn_q       <= 1'b1;
      wrn_q       <= 1'b1;
      cen_q       <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid_i && cmd_ready_q) begin
            write_q     <= cmd_write_i;
            addr_q      <= cmd_addr_i;
            if (cmd_write_i) begin
              data_q <= cmd_wdata_i;
              oe_q   <= 1'b1;
            end
            cen_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            cnt_q       <= CNT_W'(SETUP_CYCLES);
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          if (last_q) begin
            if (write_q) wrn_q <= 1'b0;
            else         rdn_q <= 1'b0;
            cnt_q   <= CNT_W'(STROBE_CYCLES);
            state_q <= STROBE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        STROBE: begin
          if (last_q) begin
            // Read byte is captured while rdn is still low, on the edge that releases it.
            if (!write_q) rsp_rdata_q <= usb_data_i;
            rdn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            cnt_q   <= CNT_W'(HOLD_CYCLES);
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        HOLD: begin
          if (last_q) begin
            cen_q <= 1'b1;
            oe_q  <= 1'b0;
            if (write_q) begin
              busy_q      <= 1'b0;
              cmd_ready_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign busy_o        = busy_q;
  assign usb_addr_o    = addr_q;
  assign usb_data_o    = data_q;
  assign usb_data_oe_o = oe_q;
  assign usb_rdn_o     = rdn_q;
  assign usb_wrn_o     = wrn_q;
  assign usb_cen_o     = cen_q;

endmodule

// File: tb/tb_cw305_usb_master.sv
// Bench for cw305_usb_master: directed timing checks at S/T/H = 1/2/1 and
// randomized traffic at 3/4/2 against a register-file responder and a reference memory.
module tb_cw305_usb_master;
  localparam int AW = 21;
  localparam int SA = 1, TA = 2, HA = 1;
  localparam int SB = 3, TB = 4, HB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: default timing
  logic          rst_a, cmd_valid_a, cmd_ready_a, cmd_write_a;
  logic [AW-1:0] cmd_addr_a;
  logic [7:0]    cmd_wdata_a;
  logic          rsp_valid_a, rsp_ready_a, busy_a;
  logic [7:0]    rsp_rdata_a;
  logic [AW-1:0] usb_addr_a;
  logic [7:0]    usb_dout_a, usb_din_a, rd_byte_a;
  logic          oe_a, rdn_a, wrn_a, cen_a;

  assign usb_din_a = rdn_a ? 8'hC3 : rd_byte_a;

  cw305_usb_master #(.pADDR_WIDTH(AW), .SETUP_CYCLES(SA), .STROBE_CYCLES(TA), .HOLD_CYCLES(HA)) dut_a (
    .clk_i(clk), .rst_i(rst_a),
    .cmd_valid_i(cmd_valid_a), .cmd_ready_o(cmd_ready_a), .cmd_write_i(cmd_write_a),
    .cmd_addr_i(cmd_addr_a), .cmd_wdata_i(cmd_wdata_a),
    .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready_a), .rsp_rdata_o(rsp_rdata_a),
    .busy_o(busy_a), .usb_addr_o(usb_addr_a), .usb_data_o(usb_dout_a),
    .usb_data_oe_o(oe_a), .usb_data_i(usb_din_a),
    .usb_rdn_o(rdn_a), .usb_wrn_o(wrn_a), .usb_cen_o(cen_a)
  );

  // Instance B: stretched timing, register-file responder
  logic          rst_b, cmd_valid_b, cmd_ready_b, cmd_write_b;
  logic [AW-1:0] cmd_addr_b;
  logic [7:0]    cmd_wdata_b;
  logic          rsp_valid_b, rsp_ready_b, busy_b;
  logic [7:0]    rsp_rdata_b;
  logic [AW-1:0] usb_addr_b;
  logic [7:0]    usb_dout_b, usb_din_b;
  logic          oe_b, rdn_b, wrn_b, cen_b;
  logic [7:0]    mem_b [0:63];
  logic [7:0]    ref_mem [0:63];

  always @(posedge clk) begin
    if (rst_b) begin
      for (int i = 0; i < 64; i++) mem_b[i] <= 8'(i) ^ 8'h5A;
    end else if (!cen_b && !wrn_b && oe_b) begin
      mem_b[usb_addr_b[5:0]] <= usb_dout_b;
    end
  end
  assign usb_din_b = rdn_b ? 8'hEE : mem_b[usb_addr_b[5:0]];

  cw305_usb_master #(.pADDR_WIDTH(AW), .SETUP_CYCLES(SB), .STROBE_CYCLES(TB), .HOLD_CYCLES(HB)) dut_b (
    .clk_i(clk), .rst_i(rst_b),
    .cmd_valid_i(cmd_valid_b), .cmd_ready_o(cmd_ready_b), .cmd_write_i(cmd_write_b),
    .cmd_addr_i(cmd_addr_b), .cmd_wdata_i(cmd_wdata_b),
    .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready_b), .rsp_rdata_o(rsp_rdata_b),
    .busy_o(busy_b), .usb_addr_o(usb_addr_b), .usb_data_o(usb_dout_b),
    .usb_data_oe_o(oe_b), .usb_data_i(usb_din_b),
    .usb_rdn_o(rdn_b), .usb_wrn_o(wrn_b), .usb_cen_o(cen_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue_a(input logic wr, input logic [AW-1:0] ad, input logic [7:0] d);
    int n = 0;
    while (!cmd_ready_a && n < 50) begin step(); n++; end
    chk("a_ready_wait", 32'(cmd_ready_a), 32'd1);
    cmd_write_a = wr; cmd_addr_a = ad; cmd_wdata_a = d; cmd_valid_a = 1'b1;
    step();
    cmd_valid_a = 1'b0; cmd_addr_a = '1; cmd_wdata_a = ~d; cmd_write_a = ~wr;
  endtask

  task automatic txn_b(input logic wr, input logic [5:0] ad, input logic [7:0] d);
    int n = 0, k = 0, cenw = 0, stw = 0, first_st = -1, bad = 0, lat = -1;
    while (!cmd_ready_b && n < 80) begin step(); n++; end
    chk("b_ready_wait", 32'(cmd_ready_b), 32'd1);
    cmd_write_b = wr; cmd_addr_b = AW'(ad); cmd_wdata_b = d; cmd_valid_b = 1'b1;
    step();
    cmd_valid_b = 1'b0; cmd_addr_b = AW'($urandom); cmd_wdata_b = 8'($urandom); cmd_write_b = ~wr;
    rsp_ready_b = 1'($urandom_range(0, 1));
    while (k < 60) begin
      if (!rdn_b && !wrn_b) bad++;
      if ((!rdn_b || !wrn_b) && cen_b) bad++;
      if (wr ? !rdn_b : !wrn_b) bad++;
      if (!cen_b) cenw++;
      if (wr ? !wrn_b : !rdn_b) begin
        if (first_st < 0) first_st = k;
        stw++;
      end
      if (wr && cmd_ready_b) break;
      if (!wr && rsp_valid_b) begin
        lat = k;
        chk("b_rdata", 32'(rsp_rdata_b), 32'(ref_mem[ad]));
        rsp_ready_b = 1'b1;
        step();
        chk("b_rsp_clear", 32'(rsp_valid_b), 32'd0);
        rsp_ready_b = 1'b0;
        break;
      end
      step();
      k++;
    end
    chk("b_cen_width", 32'(cenw), 32'(SB + TB + HB));
    chk("b_strobe_width", 32'(stw), 32'(TB));
    chk("b_strobe_start", 32'(first_st), 32'(SB));
    chk("b_protocol", 32'(bad), 32'd0);
    if (wr) begin
      chk("b_wr_latency", 32'(k), 32'(SB + TB + HB));
      ref_mem[ad] = d;
    end else begin
      chk("b_rd_latency", 32'(lat), 32'(SB + TB + HB));
    end
  endtask

  initial begin
    logic [5:0] e6;
    int acc, nf, cen_hi, seen;
    int f[3];
    logic prev_wrn;

    rst_a = 1'b1; cmd_valid_a = 1'b0; cmd_write_a = 1'b0; cmd_addr_a = '0; cmd_wdata_a = '0;
    rsp_ready_a = 1'b0; rd_byte_a = 8'h00;
    rst_b = 1'b1; cmd_valid_b = 1'b0; cmd_write_b = 1'b0; cmd_addr_b = '0; cmd_wdata_b = '0;
    rsp_ready_b = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    repeat (3) step();

    // Reset values
    chk("a_reset_bus", 32'({usb_addr_a == '0, usb_dout_a, oe_a, rdn_a, wrn_a, cen_a}), 32'({1'b1, 8'h00, 4'b0111}));
    chk("a_reset_ctl", 32'({cmd_ready_a, rsp_valid_a, rsp_rdata_a, busy_a}), 32'd0);
    chk("b_reset_ctl", 32'({cmd_ready_b, rsp_valid_b, busy_b, rdn_b, wrn_b, cen_b}), 32'b000111);
    rst_a = 1'b0; rst_b = 1'b0;
    step();
    chk("a_ready_after_reset", 32'(cmd_ready_a), 32'd1);

    // Single write 0x13 <- 0xA5
    issue_a(1'b1, 21'h00013, 8'hA5);
    for (int k = 0; k <= 5; k++) begin
      e6 = {(k < SA + TA + HA) ? 1'b0 : 1'b1,
            (k >= SA && k < SA + TA) ? 1'b0 : 1'b1,
            1'b1,
            (k < SA + TA + HA) ? 1'b1 : 1'b0,
            (k >= SA + TA + HA) ? 1'b1 : 1'b0,
            (k < SA + TA + HA) ? 1'b1 : 1'b0};
      chk("wr_ctl", 32'({cen_a, wrn_a, rdn_a, oe_a, cmd_ready_a, busy_a}), 32'(e6));
      chk("wr_bus", 32'({usb_addr_a, usb_dout_a}), 32'({21'h00013, 8'hA5}));
      step();
    end

    // Single read of 0x04, consumer always ready
    rd_byte_a = 8'h3C; rsp_ready_a = 1'b1;
    issue_a(1'b0, 21'h00004, 8'h00);
    for (int k = 0; k <= 5; k++) begin
      e6 = {(k < SA + TA + HA) ? 1'b0 : 1'b1,
            1'b1,
            (k >= SA && k < SA + TA) ? 1'b0 : 1'b1,
            1'b0,
            (k == SA + TA + HA) ? 1'b1 : 1'b0,
            (k <= SA + TA + HA) ? 1'b1 : 1'b0};
      chk("rd_ctl", 32'({cen_a, wrn_a, rdn_a, oe_a, rsp_valid_a, busy_a}), 32'(e6));
      if (k < SA + TA + HA) chk("rd_addr", 32'(usb_addr_a), 32'h4);
      if (k == SA + TA + HA) chk("rd_data", 32'(rsp_rdata_a), 32'h3C);
      step();
    end

    // Read with the consumer stalled for 10 cycles
    rd_byte_a = 8'h96; rsp_ready_a = 1'b0;
    issue_a(1'b0, 21'h1ABCD, 8'h00);
    repeat (SA + TA + HA) step();
    for (int i = 0; i < 10; i++) begin
      chk("rsp_hold", 32'({rsp_valid_a, rsp_rdata_a, cmd_ready_a, cen_a, rdn_a, wrn_a, oe_a, busy_a}),
          32'({1'b1, 8'h96, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}));
      step();
    end
    rsp_ready_a = 1'b1;
    step();
    chk("rsp_clear", 32'({rsp_valid_a, cmd_ready_a, busy_a}), 32'b010);
    rsp_ready_a = 1'b0;

    // Three back-to-back writes with valid held high
    cmd_write_a = 1'b1; cmd_addr_a = 21'h00020; cmd_wdata_a = 8'h5A; cmd_valid_a = 1'b1;
    acc = 0; nf = 0; cen_hi = 0; prev_wrn = 1'b1;
    f[0] = 0; f[1] = 0; f[2] = 0;
    for (int t = 0; t < 25; t++) begin
      if (cmd_valid_a && cmd_ready_a) acc++;
      step();
      if (acc == 3) cmd_valid_a = 1'b0;
      if (!wrn_a && prev_wrn) begin
        if (nf < 3) f[nf] = t;
        nf++;
      end
      prev_wrn = wrn_a;
      if (nf >= 1 && nf < 3 && cen_a) cen_hi++;
    end
    chk("b2b_accepts", 32'(acc), 32'd3);
    chk("b2b_pulses", 32'(nf), 32'd3);
    chk("b2b_gap1", 32'(f[1] - f[0]), 32'(SA + TA + HA + 1));
    chk("b2b_gap2", 32'(f[2] - f[1]), 32'(SA + TA + HA + 1));
    chk("b2b_cen_idle", 32'(cen_hi), 32'd2);

    // Reset during the strobe of a read
    rd_byte_a = 8'h77; rsp_ready_a = 1'b0;
    issue_a(1'b0, 21'h00055, 8'h00);
    repeat (SA) step();
    chk("pre_rst_rdn", 32'(rdn_a), 32'd0);
    rst_a = 1'b1;
    step();
    chk("rst_mid", 32'({rdn_a, wrn_a, cen_a, oe_a, rsp_valid_a, busy_a, cmd_ready_a, usb_addr_a == '0}),
        32'b11100001);
    rst_a = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rsp_valid_a) seen++;
    end
    chk("no_rsp_after_rst", 32'(seen), 32'd0);
    chk("ready_after_rst", 32'(cmd_ready_a), 32'd1);

    // Randomized traffic on the stretched-timing instance
    for (int n = 0; n < 200; n++) begin
      txn_b(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
